// File: rtl/sa_result_drain.sv
// rtl/sa_result_drain.sv - systolic array result drain: vector capture, 2-slot buffer, row serializer (optional SA_DRAIN_SAT_EN output saturation)
module sa_result_drain #(
  parameter int ROWS   = 8,
  parameter int DATA_W = 32
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [ROWS*DATA_W-1:0]     i_rres,
  input  logic [ROWS-1:0]            i_rvalid,
  output logic                       o_outread,
  output logic [DATA_W-1:0]          o_out_data,
  output logic [$clog2(ROWS)-1:0]    o_out_row,
  output logic                       o_out_last,
  output logic                       o_out_valid,
  input  logic                       i_out_ready,
  output logic                       o_overrun
);

  localparam int RW = $clog2(ROWS);
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

  localparam logic [1:0] S_WAIT = 2'd0;
  localparam logic [1:0] S_ACK  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic [1:0]        r_state;
  logic              r_wp;
  logic              r_rp;
  logic [1:0]        r_cnt;
  logic [RW-1:0]     r_rc;
  logic [1:0]        r_ovf_cnt;
  logic              r_overrun;
  logic [DATA_W-1:0] r_slot [2][ROWS];

  logic              w_all_valid;
  logic              w_capture;
  logic              w_pop;
  logic              w_pop_last;
  logic              w_ovf_cond;
  logic [DATA_W-1:0] w_raw;
  logic [DATA_W-1:0] w_shaped;

  assign w_all_valid = &i_rvalid;
  // Reset gates the acknowledge so a vector offered during reset stays with the core.
  assign w_capture   = (r_state == S_WAIT) && w_all_valid && (r_cnt != 2'd2) && !i_rst;
  assign w_pop       = (r_cnt != 2'd0) && i_out_ready;
  assign w_pop_last  = w_pop && (r_rc == LAST_ROW);
  assign w_ovf_cond  = (r_state == S_WAIT) && w_all_valid && (r_cnt == 2'd2);

  // Capture handshake: WAIT -> ACK -> HOLD -> WAIT, rvalid ignored outside WAIT.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_WAIT;
    end else begin
      case (r_state)
        S_WAIT:  if (w_capture) r_state <= S_ACK;
        S_ACK:   r_state <= S_HOLD;
        default: r_state <= S_WAIT;
      endcase
    end
  end

  // Slot pointers, occupancy and drain row counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wp  <= 1'b0;
      r_rp  <= 1'b0;
      r_cnt <= 2'd0;
      r_rc  <= '0;
    end else begin
      if (w_capture) r_wp <= ~r_wp;
      if (w_pop) r_rc <= (r_rc == LAST_ROW) ? '0 : r_rc + RW'(1);
      if (w_pop_last) r_rp <= ~r_rp;
      case ({w_capture, w_pop_last})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Vector storage; contents are only observed while the slot is occupied.
  always_ff @(posedge i_clk) begin
    if (w_capture) begin
      for (int r = 0; r < ROWS; r++) begin
        r_slot[r_wp][r] <= i_rres[r*DATA_W +: DATA_W];
      end
    end
  end

  // Sticky overrun after 3 consecutive blocked full-vector cycles.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ovf_cnt <= 2'd0;
      r_overrun <= 1'b0;
    end else if (w_ovf_cond) begin
      if (r_ovf_cnt != 2'd3) r_ovf_cnt <= r_ovf_cnt + 2'd1;
      if (r_ovf_cnt >= 2'd2) r_overrun <= 1'b1;
    end else begin
      r_ovf_cnt <= 2'd0;
    end
  end

  assign w_raw = r_slot[r_rp][r_rc];

`ifdef SA_DRAIN_SAT_EN
  localparam logic signed [DATA_W-1:0] SAT_MAX = DATA_W'(32767);
  localparam logic signed [DATA_W-1:0] SAT_MIN = DATA_W'(-32768);

  // Clamp to signed 16-bit range on the way out; stored data is untouched.
  always_comb begin
    w_shaped = w_raw;
    if ($signed(w_raw) > SAT_MAX)      w_shaped = SAT_MAX;
    else if ($signed(w_raw) < SAT_MIN) w_shaped = SAT_MIN;
  end
`else
  assign w_shaped = w_raw;
`endif

  assign o_outread   = w_capture;
  assign o_out_valid = (r_cnt != 2'd0);
  assign o_out_data  = o_out_valid ? w_shaped : '0;
  assign o_out_row   = r_rc;
  assign o_out_last  = (r_rc == LAST_ROW);
  assign o_overrun   = r_overrun;

endmodule

// File: tb/tb_sa_result_drain.sv
// tb/tb_sa_result_drain.sv - randomized self-checking bench for sa_result_drain
module tb_sa_result_drain;

  localparam int ROWS = 8;
  localparam int DW   = 32;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [ROWS*DW-1:0]   rres;
  logic [ROWS-1:0]      rvalid;
  logic                 out_ready;
  logic                 outread;
  logic [DW-1:0]        out_data;
  logic [2:0]           out_row;
  logic                 out_last;
  logic                 out_valid;
  logic                 overrun;

  sa_result_drain #(.ROWS(ROWS), .DATA_W(DW)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_rres      (rres),
    .i_rvalid    (rvalid),
    .o_outread   (outread),
    .o_out_data  (out_data),
    .o_out_row   (out_row),
    .o_out_last  (out_last),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_overrun   (overrun)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: pending beats of buffered vectors, capture spacing, overrun run length.
  logic [DW-1:0]      exp_q[$];
  int                 exp_rq[$];
  int                 since   = 10;
  int                 ovf_run = 0;
  bit                 exp_ovf = 1'b0;
  // Core model: vectors waiting to be offered, one idle cycle after each retire.
  logic [ROWS*DW-1:0] pend_q[$];
  int                 core_gap = 0;
  bit                 partial  = 1'b0;
  int                 dut_caps  = 0;
  int                 dut_beats = 0;

  function automatic logic [DW-1:0] shape(input logic [DW-1:0] v);
`ifdef SA_DRAIN_SAT_EN
    if ($signed(v) > 32767)  return 32'd32767;
    if ($signed(v) < -32768) return 32'hFFFF8000;
`endif
    return v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [ROWS*DW-1:0] rand_vec();
    logic [ROWS*DW-1:0] v;
    for (int r = 0; r < ROWS; r++) v[r*DW +: DW] = $urandom;
    return v;
  endfunction

  task automatic cycle();
    logic exp_rd;
    bit   all_v;
    int   nvec;
    if (partial) rvalid = 8'h7F;
    else if (core_gap == 0 && pend_q.size() > 0) begin
      rres   = pend_q[0];
      rvalid = '1;
    end else rvalid = '0;
    @(negedge clk);
    all_v  = &rvalid;
    nvec   = (exp_q.size() + ROWS - 1) / ROWS;
    exp_rd = all_v && (nvec < 2) && (since >= 3) && !rst;
    chk("outread", outread, exp_rd);
    if (outread) dut_caps++;
    if (!rst) begin
      chk("out_valid", out_valid, exp_q.size() > 0);
      if (exp_q.size() > 0) begin
        chk("out_data", out_data, shape(exp_q[0]));
        chk("out_row", out_row, exp_rq[0]);
        chk("out_last", out_last, exp_rq[0] == ROWS - 1);
        if (out_ready) begin
          void'(exp_q.pop_front());
          void'(exp_rq.pop_front());
        end
      end
      if (out_valid && out_ready) dut_beats++;
      chk("overrun", overrun, exp_ovf);
      if (all_v && nvec == 2 && since >= 3) ovf_run++;
      else ovf_run = 0;
      if (ovf_run >= 3) exp_ovf = 1'b1;
    end
    if (exp_rd) begin
      for (int r = 0; r < ROWS; r++) begin
        exp_q.push_back(rres[r*DW +: DW]);
        exp_rq.push_back(r);
      end
      since = 0;
      void'(pend_q.pop_front());
      core_gap = 1;
    end else if (core_gap > 0) core_gap--;
    if (since < 10) since++;
    if (rst) begin
      exp_q.delete();
      exp_rq.delete();
      since   = 10;
      ovf_run = 0;
      exp_ovf = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  // mode 0: ready high, 1: alternate 1/0, 2: random
  task automatic run_until_idle(input int mode, input int maxc);
    int n;
    n = 0;
    while ((exp_q.size() > 0 || pend_q.size() > 0) && n < maxc) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (n % 2 == 0);
        default: out_ready = $urandom_range(0, 1);
      endcase
      cycle();
      n++;
    end
    chk("drain_in_budget", n < maxc, 1);
    out_ready = 1'b1;
    cycle();
  endtask

  initial begin
    logic [ROWS*DW-1:0] v;
    rst = 1'b1; rres = '0; rvalid = '0; out_ready = 1'b0;
    cycle();
    cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_row", out_row, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_outread", outread, 0);
    chk("rst_overrun", overrun, 0);
    @(posedge clk);
    #1;

    // single vector 100+r
    for (int r = 0; r < ROWS; r++) v[r*DW +: DW] = 100 + r;
    pend_q.push_back(v);
    dut_caps = 0; dut_beats = 0;
    run_until_idle(0, 60);
    chk("single_acks", dut_caps, 1);
    chk("single_beats", dut_beats, 8);

    // backpressure 1,0,1,0
    pend_q.push_back(rand_vec());
    dut_caps = 0; dut_beats = 0;
    run_until_idle(1, 80);
    chk("bp_beats", dut_beats, 8);

    // random traffic, random ready
    for (int i = 0; i < 4; i++) pend_q.push_back(rand_vec());
    dut_caps = 0; dut_beats = 0;
    run_until_idle(2, 400);
    chk("rand_acks", dut_caps, 4);
    chk("rand_beats", dut_beats, 32);

    // partial valid never captured
    partial = 1'b1; dut_caps = 0;
    repeat (10) cycle();
    partial = 1'b0;
    chk("partial_acks", dut_caps, 0);
    chk("partial_valid", out_valid, 0);

    // buffer full with ready held low
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) pend_q.push_back(rand_vec());
    dut_caps = 0; dut_beats = 0;
    repeat (15) cycle();
    chk("full_acks", dut_caps, 2);
    chk("full_overrun", overrun, 1);
    run_until_idle(0, 80);
    chk("full_acks_after", dut_caps, 3);
    chk("full_beats", dut_beats, 24);

    // reset mid-drain, then re-present
    v = rand_vec();
    pend_q.push_back(v);
    out_ready = 1'b1; dut_beats = 0;
    for (int n = 0; n < 30 && dut_beats < 3; n++) cycle();
    chk("pre_rst_beats", dut_beats, 3);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    rvalid = '0;
    @(negedge clk);
    chk("post_rst_valid", out_valid, 0);
    chk("post_rst_row", out_row, 0);
    chk("post_rst_overrun", overrun, 0);
    @(posedge clk);
    #1;
    pend_q.push_back(v);
    dut_caps = 0; dut_beats = 0;
    run_until_idle(0, 60);
    chk("rst_redrain_beats", dut_beats, 8);

    // saturation boundary values
    v = rand_vec();
    v[0*DW +: DW] = 32'd40000;
    v[1*DW +: DW] = 32'hFFFF63C0;
    v[2*DW +: DW] = 32'd32767;
    v[3*DW +: DW] = 32'hFFFF8000;
    pend_q.push_back(v);
    dut_beats = 0;
    run_until_idle(0, 60);
    chk("sat_beats", dut_beats, 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
